instr_fetch_stage: RTL

//  IF stage of the Cardinal processor: owns the PC, drives the 8-bit word address to the

---
 rtl/instr_fetch_stage.sv | 77 +++++++
 1 files changed

// File: rtl/instr_fetch_stage.sv
// Cardinal IF stage: owns the PC, addresses the async-read imem and registers the fetched
// word into the IF/ID latch. Handles stall, branch redirect/flush and halt on the end-of-program word.
module instr_fetch_stage #(
  parameter int                   ADDR_W    = 8,
  parameter int                   INSTR_W   = 32,
  parameter logic [0:INSTR_W-1]   HALT_WORD = '0,
  parameter int                   CNT_W     = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [0:ADDR_W-1]   branch_target_i,
  input  logic [0:INSTR_W-1]  Instruction,
  output logic [0:ADDR_W-1]   Instr_Addr,
  output logic [0:INSTR_W-1]  if_id_instr,
  output logic [0:ADDR_W-1]   if_id_pc,
  output logic                if_id_valid,
  output logic                halt_o,
  output logic [0:CNT_W-1]    fetch_cnt_o
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [0:ADDR_W-1] pc;

  assign Instr_Addr = pc;

  function automatic logic [0:CNT_W-1] sat_inc(input logic [0:CNT_W-1] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= RUN;
      pc          <= '0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halt_o      <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken_i) begin
            // Redirect wins over stall and over a halt word on the wrong path.
            pc          <= branch_target_i;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
          end else if (stall_i) begin
            pc <= pc;
          end else if (Instruction == HALT_WORD) begin
            if_id_instr <= Instruction;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            fetch_cnt_o <= sat_inc(fetch_cnt_o);
            halt_o      <= 1'b1;
            state       <= HALT;
          end else begin
            if_id_instr <= Instruction;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
            fetch_cnt_o <= sat_inc(fetch_cnt_o);
          end
        end
        HALT: begin
          // Terminal: only bubbles leave IF/ID until Reset.
          if_id_valid <= 1'b0;
          halt_o      <= 1'b1;
        end
      endcase
    end
  end

endmodule
